// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped,
// write-through cache level.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      FILL_REQ,
      FILL_REL,
      WR_REQ,
      WR_REL,
      DONE
   } state_e;

   function automatic int off_w(input int block_words);
      return $clog2(block_words);
   endfunction

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int num_lines, input int block_words);
      return addr_w - idx_w(num_lines) - off_w(block_words);
   endfunction

   // Select/counter width that never collapses to zero bits.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_level_if.sv
// Upstream request/complete port plus the downstream port of the same
// protocol, bundled so the cache sees one slave view and the environment one master view.
interface cache_level_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] addr;
   logic              enable;
   logic              write;
   logic [DATA_W-1:0] dataIn;
   logic              requestComplete;
   logic [DATA_W-1:0] dataOut;

   logic [ADDR_W-1:0] memAddr;
   logic              memEnable;
   logic              memWrite;
   logic [DATA_W-1:0] memDataIn;
   logic              memComplete;
   logic [DATA_W-1:0] memDataOut;

   modport slave (
      input  addr, enable, write, dataIn, memComplete, memDataOut,
      output requestComplete, dataOut, memAddr, memEnable, memWrite, memDataIn
   );

   modport master (
      output addr, enable, write, dataIn, memComplete, memDataOut,
      input  requestComplete, dataOut, memAddr, memEnable, memWrite, memDataIn
   );
endinterface

// File: rtl/cache_line_store.sv
// Valid bits, tag array and data array of the cache: one combinational lookup
// port, one word write port and a strobe that validates a line with its tag.
module cache_line_store #(
   parameter int DATA_W      = 32,
   parameter int NUM_LINES   = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int TAG_W       = 10,
   parameter int IDX_W       = 4,
   parameter int WSEL_W      = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx_i,
   input  logic [WSEL_W-1:0] rd_off_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [WSEL_W-1:0] wr_off_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              val_en_i,
   input  logic [IDX_W-1:0]  val_idx_i,
   input  logic [TAG_W-1:0]  val_tag_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [DATA_W-1:0]    data_q [NUM_LINES][BLOCK_WORDS];

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (val_en_i) begin
         valid_q[val_idx_i] <= 1'b1;
      end
   end

   // Tags and data carry no reset; valid_q alone decides whether they mean anything.
   always_ff @(posedge clock) begin
      if (val_en_i) begin
         tag_q[val_idx_i] <= val_tag_i;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/cache_level.sv
// One direct-mapped, write-through, no-write-allocate cache level: responder
// upstream, initiator of the same 4-phase handshake downstream.
module cache_level
   import cache_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int NUM_LINES   = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int HIT_DELAY   = 1
) (
   input  logic         clock,
   input  logic         reset,
   cache_level_if.slave bus
);

   localparam int OFF_W  = off_w(BLOCK_WORDS);
   localparam int IDX_W  = idx_w(NUM_LINES);
   localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, BLOCK_WORDS);
   localparam int WSEL_W = sel_w(BLOCK_WORDS);
   localparam int DLY_W  = sel_w(HIT_DELAY);

   localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(BLOCK_WORDS - 1);
   localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(HIT_DELAY - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLOCK_WORDS - 1);

   state_e            state_q, state_d;
   logic [DLY_W-1:0]  cnt_q, cnt_d;
   logic [WSEL_W-1:0] wcnt_q, wcnt_d;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              req_cpl_q, req_cpl_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic [WSEL_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [ADDR_W-1:0] line_base;
   logic [WSEL_W-1:0] wcnt_nx;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic              hit;
   logic              st_wr_en;
   logic [WSEL_W-1:0] st_wr_off;
   logic [DATA_W-1:0] st_wr_data;
   logic              st_val_en;

   assign off       = WSEL_W'(addr_q & OFF_MASK);
   assign idx       = IDX_W'(addr_q >> OFF_W);
   assign tag       = TAG_W'(addr_q >> (OFF_W + IDX_W));
   assign line_base = addr_q & ~OFF_MASK;
   assign wcnt_nx   = wcnt_q + WSEL_W'(1);
   assign hit       = rd_valid && (rd_tag == tag);

   cache_line_store #(
      .DATA_W     (DATA_W),
      .NUM_LINES  (NUM_LINES),
      .BLOCK_WORDS(BLOCK_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .WSEL_W     (WSEL_W)
   ) u_store (
      .clock     (clock),
      .reset     (reset),
      .rd_idx_i  (idx),
      .rd_off_i  (off),
      .rd_valid_o(rd_valid),
      .rd_tag_o  (rd_tag),
      .rd_data_o (rd_data),
      .wr_en_i   (st_wr_en),
      .wr_idx_i  (idx),
      .wr_off_i  (st_wr_off),
      .wr_data_i (st_wr_data),
      .val_en_i  (st_val_en),
      .val_idx_i (idx),
      .val_tag_i (tag)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      hit_d       = hit_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      req_cpl_d   = req_cpl_q;
      data_out_d  = data_out_q;
      mem_addr_d  = mem_addr_q;
      mem_en_d    = mem_en_q;
      mem_wr_d    = mem_wr_q;
      mem_wdata_d = mem_wdata_q;
      st_wr_en    = 1'b0;
      st_wr_off   = off;
      st_wr_data  = wdata_q;
      st_val_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               addr_d  = bus.addr;
               write_d = bus.write;
               wdata_d = bus.dataIn;
               cnt_d   = DLY_LOAD;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DLY_W'(1);
            end else if (write_q) begin
               // Hit status is frozen here so the line is updated only once memory accepts the write.
               hit_d       = hit;
               mem_en_d    = 1'b1;
               mem_wr_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = wdata_q;
               state_d     = WR_REQ;
            end else if (hit) begin
               data_out_d = rd_data;
               req_cpl_d  = 1'b1;
               state_d    = DONE;
            end else begin
               wcnt_d     = '0;
               mem_en_d   = 1'b1;
               mem_wr_d   = 1'b0;
               mem_addr_d = line_base;
               state_d    = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (bus.memComplete) begin
               st_wr_en   = 1'b1;
               st_wr_off  = wcnt_q;
               st_wr_data = bus.memDataOut;
               mem_en_d   = 1'b0;
               state_d    = FILL_REL;
            end
         end
         FILL_REL: begin
            if (!bus.memComplete) begin
               if (wcnt_q == LAST_WORD) begin
                  st_val_en  = 1'b1;
                  data_out_d = rd_data;
                  req_cpl_d  = 1'b1;
                  state_d    = DONE;
               end else begin
                  wcnt_d     = wcnt_nx;
                  mem_en_d   = 1'b1;
                  mem_addr_d = line_base | ADDR_W'(wcnt_nx);
                  state_d    = FILL_REQ;
               end
            end
         end
         WR_REQ: begin
            if (bus.memComplete) begin
               st_wr_en = hit_q;
               mem_en_d = 1'b0;
               mem_wr_d = 1'b0;
               state_d  = WR_REL;
            end
         end
         WR_REL: begin
            if (!bus.memComplete) begin
               req_cpl_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (!bus.enable) begin
               req_cpl_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         hit_q       <= 1'b0;
         req_cpl_q   <= 1'b0;
         data_out_q  <= '0;
         mem_addr_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         hit_q       <= hit_d;
         req_cpl_q   <= req_cpl_d;
         data_out_q  <= data_out_d;
         mem_addr_q  <= mem_addr_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Request fields are only meaningful after acceptance, so they skip reset.
   always_ff @(posedge clock) begin
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
   end

   assign bus.requestComplete = req_cpl_q;
   assign bus.dataOut         = data_out_q;
   assign bus.memAddr         = mem_addr_q;
   assign bus.memEnable       = mem_en_q;
   assign bus.memWrite        = mem_wr_q;
   assign bus.memDataIn       = mem_wdata_q;

endmodule

// File: tb/tb_cache_level.sv
// Directed bench for cache_level: a 5-cycle downstream memory model logs every
// downstream access, and a scoreboard of expected accesses is compared per request.
module tb_cache_level;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 32;
   localparam int HIT_DELAY = 1;
   localparam int MEM_LAT   = 5;

   typedef logic [48:0] acc_t;  // {write, addr, data}

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_level_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   cache_level #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .NUM_LINES  (16),
      .BLOCK_WORDS(4),
      .HIT_DELAY  (HIT_DELAY)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
   );

   acc_t        obs_q[$];
   acc_t        exp_q[$];
   logic [31:0] mem_written [int];
   logic [31:0] exp_mem [int];
   int          mem_cnt;
   int          checks = 0;
   int          passed = 0;
   int          fails  = 0;
   int          rd_ptr = 0;

   // Downstream memory: mem[a] = a + 0x1000 unless written; completes MEM_LAT cycles after enable.
   always @(negedge clk) begin
      if (!rst_n || !bus.memEnable) begin
         mem_cnt         = 0;
         bus.memComplete = 1'b0;
         if (!rst_n) bus.memDataOut = '0;
      end else if (!bus.memComplete) begin
         mem_cnt++;
         if (mem_cnt == MEM_LAT) begin
            if (bus.memWrite) begin
               mem_written[int'(bus.memAddr)] = bus.memDataIn;
               obs_q.push_back({1'b1, bus.memAddr, bus.memDataIn});
            end else begin
               bus.memDataOut = mem_written.exists(int'(bus.memAddr)) ?
                                mem_written[int'(bus.memAddr)] : 32'(bus.memAddr) + 32'h1000;
               obs_q.push_back({1'b0, bus.memAddr, bus.memDataOut});
            end
            bus.memComplete = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_bench();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   endtask

   function automatic logic [31:0] exp_val(input logic [15:0] a);
      return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'(a) + 32'h1000;
   endfunction

   task automatic push_fill(input logic [15:0] a);
      logic [15:0] base;
      base = a & 16'hFFFC;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, base + 16'(i), exp_val(base + 16'(i))});
      end
   endtask

   task automatic check_accesses(input string tag);
      int n_obs;
      n_obs = obs_q.size() - rd_ptr;
      chk({tag, "_nacc"}, 64'(n_obs), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n_obs) chk({tag, "_acc"}, 64'(obs_q[rd_ptr + i]), 64'(exp_q[i]));
      end
      rd_ptr = obs_q.size();
      exp_q.delete();
   endtask

   // Called at a negedge; returns at a negedge after requestComplete has fallen.
   task automatic xact(input logic [15:0] a, input logic w, input logic [31:0] d, input int hold,
                       output logic [31:0] rdata, output int lat);
      bus.addr   = a;
      bus.write  = w;
      bus.dataIn = d;
      bus.enable = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.requestComplete && lat < 1000);
      if (!bus.requestComplete) begin
         chk("req_timeout", 64'(bus.requestComplete), 64'(1));
         finish_bench();
      end
      rdata = bus.dataOut;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_cpl", 64'(bus.requestComplete), 64'(1));
      end
      bus.enable = 1'b0;
      @(posedge clk);
      #1 chk("cpl_fall", 64'(bus.requestComplete), 64'(0));
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp_d,
                     input bit exp_hit, input int hold);
      logic [31:0] rdata;
      int          lat;
      if (!exp_hit) push_fill(a);
      xact(a, 1'b0, 32'h0, hold, rdata, lat);
      chk({tag, "_data"}, 64'(rdata), 64'(exp_d));
      if (exp_hit) chk({tag, "_hit_lat"}, 64'(lat), 64'(HIT_DELAY));
      else         chk({tag, "_miss_lat"}, 64'(lat > HIT_DELAY), 64'(1));
      check_accesses(tag);
   endtask

   task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d);
      logic [31:0] rdata;
      int          lat;
      exp_q.push_back({1'b1, a, d});
      exp_mem[int'(a)] = d;
      xact(a, 1'b1, d, 0, rdata, lat);
      check_accesses(tag);
   endtask

   initial begin
      int n;
      bus.addr   = '0;
      bus.write  = 1'b0;
      bus.dataIn = '0;
      bus.enable = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cpl",   64'(bus.requestComplete), 64'(0));
      chk("rst_men",   64'(bus.memEnable),       64'(0));
      chk("rst_mwr",   64'(bus.memWrite),        64'(0));
      chk("rst_dout",  64'(bus.dataOut),         64'(0));
      chk("rst_maddr", 64'(bus.memAddr),         64'(0));
      chk("rst_mdin",  64'(bus.memDataIn),       64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Cold miss, then hits within the same line
      rd("cold_rd0", 16'd0, 32'h0000_1000, 1'b0, 0);
      rd("hit_rd1",  16'd1, 32'h0000_1001, 1'b1, 0);

      // Conflict eviction on index 0
      rd("conf_rd64", 16'd64, 32'h0000_1040, 1'b0, 0);
      rd("conf_rd0",  16'd0,  32'h0000_1000, 1'b0, 0);

      // Write hit updates line and memory
      wr("wr_hit2",  16'd2, 32'hDEAD_BEEF);
      rd("rd_after_wr2", 16'd2, 32'hDEAD_BEEF, 1'b1, 0);

      // Write miss does not allocate
      wr("wr_miss100", 16'd100, 32'hCAFE_0100);
      rd("rd100", 16'd100, 32'hCAFE_0100, 1'b0, 0);
      rd("rd101", 16'd101, 32'h0000_1065, 1'b1, 0);

      // Enable held long after completion; back-to-back follow-up
      rd("hold_rd3", 16'd3, 32'h0000_1003, 1'b1, 10);
      rd("b2b_rd0",  16'd0, 32'h0000_1000, 1'b1, 0);

      // Reset during the second refill word of addr 0
      rd("pre_rst_rd64", 16'd64, 32'h0000_1040, 1'b0, 0);
      bus.addr   = 16'd0;
      bus.write  = 1'b0;
      bus.enable = 1'b1;
      n = 0;
      while (!(bus.memEnable === 1'b1 && bus.memAddr === 16'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_word1", 64'(bus.memEnable === 1'b1 && bus.memAddr === 16'd1), 64'(1));
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_men", 64'(bus.memEnable),       64'(0));
      chk("midrst_cpl", 64'(bus.requestComplete), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("postrst_cpl", 64'(bus.requestComplete), 64'(0));
         chk("postrst_men", 64'(bus.memEnable),       64'(0));
      end
      rd_ptr = obs_q.size();
      exp_q.delete();
      rd("postrst_rd1", 16'd1, 32'h0000_1001, 1'b0, 0);

      finish_bench();
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/cache_level.md
Name: cache_level

Overview:
- One level of the cache hierarchy behind the request/complete handshake that the user-side test initiator drives (addr, enable, write, dataIn, requestComplete, dataOut).
- Responder on the upstream port. Initiator of the same protocol on the downstream port, toward the next level or memory.
- Direct-mapped, word-addressed, write-through, no-write-allocate.
- Hit latency is set by a parameter, so benches can measure delay, block size and capacity.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 32, word width.
- NUM_LINES, 16, number of lines; power of two, at least 2.
- BLOCK_WORDS, 4, words per line; power of two, at least 1.
- HIT_DELAY, 1, cycles from request acceptance to requestComplete on a hit; at least 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  ADDR_W  upstream word address; stable while enable is high.
- enable  in  1  upstream request; held high until requestComplete is seen.
- write  in  1  1 = write, 0 = read; stable while enable is high.
- dataIn  in  DATA_W  upstream write data.
- requestComplete  out  1  upstream completion; level signal.
- dataOut  out  DATA_W  read data; valid while requestComplete is high.
- memAddr  out  ADDR_W  downstream word address.
- memEnable  out  1  downstream request.
- memWrite  out  1  downstream write flag.
- memDataIn  out  DATA_W  downstream write data.
- memComplete  in  1  downstream completion.
- memDataOut  in  DATA_W  downstream read data.

Behaviour:
- Reset: sampled low at a rising edge. Clears all valid bits, state goes to IDLE. requestComplete, memEnable, memWrite = 0; dataOut, memAddr, memDataIn = 0.
- Reset mid-operation: any state aborts. memEnable drops the next cycle, and the partial line is left invalid.
- Address split: offset = addr[log2(BLOCK_WORDS)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Handshake, both ports, 4-phase:
  - Enable rises with stable fields.
  - Complete rises.
  - Enable falls.
  - Complete falls the cycle after enable is sampled low.
  - A new request is accepted only from IDLE.
- IDLE:
  - On enable=1: latch addr/write/dataIn, load counter = HIT_DELAY-1, go to LOOKUP.
  - The acceptance edge is cycle 0.
- LOOKUP:
  - Count down. At zero, evaluate hit = valid[index] and tag matches.
  - Read hit: dataOut = line word, go to DONE. requestComplete is high exactly HIT_DELAY cycles after acceptance.
  - Read miss: word counter = 0, go to FILL_REQ.
  - Write (hit or miss): go to WR_REQ.
- FILL_REQ:
  - memEnable=1, memWrite=0, memAddr = {tag, index, word counter}.
  - On memComplete=1: store memDataOut into that word, go to FILL_REL.
  - Words are fetched in order 0..BLOCK_WORDS-1, starting from word 0 regardless of the requested offset.
- FILL_REL:
  - memEnable=0; wait for memComplete=0.
  - If word counter = BLOCK_WORDS-1: set valid, write tag, dataOut = requested word, go to DONE.
  - Otherwise increment the counter and go to FILL_REQ.
- WR_REQ:
  - memEnable=1, memWrite=1, memAddr=addr, memDataIn=dataIn.
  - On memComplete=1: if hit, update that line word; go to WR_REL.
  - No refill on a write miss.
- WR_REL: memEnable=0; wait for memComplete=0, then go to DONE.
- DONE: requestComplete=1 until enable is sampled 0, then requestComplete=0 and go to IDLE.
- Eviction: a miss to an occupied index overwrites tag/data. No writeback is needed (write-through).
- Downstream stalls indefinitely if memComplete never rises; no timeout.

Decomposition:
- Package cache_pkg:
  - state enum: IDLE, LOOKUP, FILL_REQ, FILL_REL, WR_REQ, WR_REL, DONE.
  - functions for offset, index and tag widths (clog2-based).
- Sub-module cache_line_store:
  - holds the valid bits, tag array and data array.
  - one lookup read port, one word write port, a line-validate strobe, and synchronous valid clear on reset.
- FSM and handshakes stay in cache_level.

Test Plan (defaults; downstream memory model with mem[a] = a + 0x1000 and 5-cycle enable-to-complete latency):
1. Cold read addr 0 -> exactly 4 downstream reads at addresses 0, 1, 2, 3 in order; dataOut = 0x1000. An immediate re-read of addr 1 completes exactly 1 cycle after acceptance with 0x1001 and no downstream activity.
2. Conflict: read 0, then read 64 (index 0, tag 1) -> refill from addresses 64..67. A following read of 0 misses and issues 4 downstream reads.
3. Write hit: after read 0, write 0xDEADBEEF to addr 2 -> one downstream write (memAddr=2, memDataIn=0xDEADBEEF). A following read of 2 hits with 1-cycle delay and returns 0xDEADBEEF.
4. Write miss addr 100 (index 9) -> one downstream write, no downstream reads. A following read of 100 misses and fetches addresses 100..103.
5. Handshake: hold enable high 10 cycles after requestComplete -> requestComplete stays 1 throughout and falls the cycle after enable is sampled 0. A second request is not accepted before that.
6. Reset (low) during the 2nd refill word of addr 0 -> memEnable is 0 the next cycle and requestComplete stays 0. After release, a read of addr 1 misses.
